round_scheduler: RTL

//  Sequences a full whack-a-light game. Runs NUM_ROUNDS rounds. Each round:
//  - waits for all buttons to be released, then a fixed gap
//  - lights one target chosen from the LFSR value
//  - judges the response within a time window
//  The window shrinks with consecutive hits. hit/miss pulses drive the score counter; done marks game end.

---
 rtl/round_scheduler_if.sv | 25 ++
 rtl/round_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/round_scheduler_if.sv
// Player-facing signals of the round scheduler: start/target/buttons in, lights and scoring out.
// Signal suffixes are from the scheduler's point of view (slave modport).
interface round_scheduler_if #(
    parameter int RND_W = 5
) ();
    logic             start_i;
    logic [1:0]       rnd_i;
    logic [3:0]       buttons_i;
    logic [3:0]       lights_o;
    logic             hit_pulse_o;
    logic             miss_pulse_o;
    logic [RND_W-1:0] round_cnt_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, rnd_i, buttons_i,
        input  lights_o, hit_pulse_o, miss_pulse_o, round_cnt_o, busy_o, done_o
    );

    modport slave (
        input  start_i, rnd_i, buttons_i,
        output lights_o, hit_pulse_o, miss_pulse_o, round_cnt_o, busy_o, done_o
    );
endinterface

// File: rtl/round_scheduler.sv
// Whack-a-light game sequencer: per round waits for release, a dark gap, lights a target
// and judges the response inside a window that shrinks with consecutive hits.
module round_scheduler #(
    parameter int NUM_ROUNDS = 16,
    parameter int RND_W      = 5,
    parameter int CNT_W      = 25,
    parameter int GAP_CYC    = 10_000_000,
    parameter int WIN_INIT   = 25_000_000,
    parameter int WIN_STEP   = 1_000_000,
    parameter int WIN_MIN    = 5_000_000
) (
    input logic              clk,
    input logic              rst,
    round_scheduler_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RELEASE = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_SHOW    = 3'd3;
    localparam logic [2:0] S_HIT     = 3'd4;
    localparam logic [2:0] S_MISS    = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_INIT_C  = CNT_W'(WIN_INIT);
    localparam logic [CNT_W-1:0] WIN_STEP_C  = CNT_W'(WIN_STEP);
    localparam logic [CNT_W-1:0] WIN_MIN_C   = CNT_W'(WIN_MIN);
    localparam logic [CNT_W:0]   WIN_FLOOR_X = (CNT_W+1)'(WIN_MIN + WIN_STEP);
    localparam logic [RND_W-1:0] RND_ONE     = RND_W'(1);
    localparam logic [RND_W-1:0] RND_LAST    = RND_W'(NUM_ROUNDS);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] window_q, window_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [3:0]       sync1_q, bs_q, bprev_q;

    logic [3:0]       tgtMask;
    logic [3:0]       rise;
    logic [RND_W-1:0] roundInc;

    assign tgtMask  = 4'b0001 << tgt_q;
    assign rise     = bs_q & ~bprev_q;
    assign roundInc = round_q + RND_ONE;

    // A pressed button on the window's last cycle is judged as a press, not a timeout.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        win_d    = win_q;
        window_d = window_q;
        tgt_d    = tgt_q;
        round_d  = round_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (bus.start_i) begin
                    state_d  = S_RELEASE;
                    round_d  = '0;
                    window_d = WIN_INIT_C;
                end
            end
            S_RELEASE: begin
                if (bs_q == 4'b0000) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SHOW;
                    tgt_d   = bus.rnd_i;
                    win_d   = window_q - CNT_ONE;
                end else begin
                    gap_d = gap_q - CNT_ONE;
                end
            end
            S_SHOW: begin
                if (rise != 4'b0000) begin
                    state_d = (rise == tgtMask && bs_q == tgtMask) ? S_HIT : S_MISS;
                end else if (win_q == '0) begin
                    state_d = S_MISS;
                end else begin
                    win_d = win_q - CNT_ONE;
                end
            end
            S_HIT, S_MISS: begin
                if (state_q == S_MISS) begin
                    window_d = WIN_INIT_C;
                end else if ({1'b0, window_q} >= WIN_FLOOR_X) begin
                    window_d = window_q - WIN_STEP_C;
                end else begin
                    window_d = WIN_MIN_C;
                end
                round_d = roundInc;
                state_d = (roundInc == RND_LAST) ? S_FINISH : S_RELEASE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gap_q    <= '0;
            win_q    <= '0;
            window_q <= WIN_INIT_C;
            tgt_q    <= '0;
            round_q  <= '0;
            sync1_q  <= '0;
            bs_q     <= '0;
            bprev_q  <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            win_q    <= win_d;
            window_q <= window_d;
            tgt_q    <= tgt_d;
            round_q  <= round_d;
            sync1_q  <= bus.buttons_i;
            bs_q     <= sync1_q;
            bprev_q  <= bs_q;
        end
    end

    assign bus.lights_o     = (state_q == S_SHOW) ? tgtMask : 4'b0000;
    assign bus.hit_pulse_o  = (state_q == S_HIT);
    assign bus.miss_pulse_o = (state_q == S_MISS);
    assign bus.round_cnt_o  = round_q;
    assign bus.busy_o       = !(state_q == S_IDLE || state_q == S_FINISH);
    assign bus.done_o       = (state_q == S_FINISH);

endmodule
